// File: rtl/fetch_ctrl_pkg.sv
// rtl/fetch_ctrl_pkg.sv - state codes and opcode constants shared by fetch_ctrl and its bench
package fetch_ctrl_pkg;

  typedef enum logic [3:0] {
    STATE_HALT   = 4'd0,
    STATE_FETCH0 = 4'd1,
    STATE_LATCH0 = 4'd2,
    STATE_FETCH1 = 4'd3,
    STATE_LATCH1 = 4'd4,
    STATE_EXEC   = 4'd5,
    STATE_PAUSE  = 4'd6
  } state_e;

  localparam logic [7:0] OP_END    = 8'hFF;
  localparam logic [7:0] OP_LIMM16 = 8'h10;
  localparam logic [7:0] OP_LIMM32 = 8'h11;
  localparam logic [7:0] OP_LBSET  = 8'h20;

endpackage

// File: rtl/fetch_ctrl_if.sv
// rtl/fetch_ctrl_if.sv - instruction-memory read bus between fetch_ctrl and the memory
interface fetch_ctrl_if;

  logic        mem_re;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output mem_re,
    output mem_addr,
    input  mem_rdata
  );

  modport slave (
    input  mem_re,
    input  mem_addr,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_ctrl_instr_len.sv
// rtl/fetch_ctrl_instr_len.sv - flags opcodes that carry a second instruction word
module instr_len
  import fetch_ctrl_pkg::*;
(
  input  logic [7:0] opcode_i,
  output logic       is_two_word_o
);

  assign is_two_word_o = (opcode_i == OP_LIMM32) || (opcode_i == OP_LBSET);

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer (optional single-step via STEP_MODE_EN)
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         exec_stall_i,
  input  logic         jump_req_i,
  input  logic [15:0]  jump_target_i,
  input  logic         step_i,
  fetch_ctrl_if.master mem_bus,
  output logic [3:0]   current_state_o,
  output logic [31:0]  instr0_o,
  output logic [31:0]  instr1_o,
  output logic [15:0]  pc_o,
  output logic         halted_o
);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] instr0_q, instr0_d;
  logic [31:0] instr1_q, instr1_d;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        two_word;

  // Length decode looks at the word arriving in LATCH0, not the latched copy.
  instr_len u_instr_len (
    .opcode_i      (mem_bus.mem_rdata[31:24]),
    .is_two_word_o (two_word)
  );

`ifndef STEP_MODE_EN
  logic unused_step;
  assign unused_step = step_i;
`endif

  // Next-state, datapath updates and memory-bus outputs.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr0_d = instr0_q;
    instr1_d = instr1_q;
    rd_en    = 1'b0;
    rd_addr  = '0;
    case (state_q)
      STATE_HALT: begin
        if (start_i) state_d = STATE_FETCH0;
      end
      STATE_FETCH0: begin
        rd_en   = 1'b1;
        rd_addr = pc_q;
        state_d = STATE_LATCH0;
      end
      STATE_LATCH0: begin
        instr0_d = mem_bus.mem_rdata;
        pc_d     = pc_q + 16'd1;
        if (two_word) begin
          state_d = STATE_FETCH1;
        end else begin
          instr1_d = '0;
          state_d  = STATE_EXEC;
        end
      end
      STATE_FETCH1: begin
        rd_en   = 1'b1;
        rd_addr = pc_q;
        state_d = STATE_LATCH1;
      end
      STATE_LATCH1: begin
        instr1_d = mem_bus.mem_rdata;
        pc_d     = pc_q + 16'd1;
        state_d  = STATE_EXEC;
      end
      STATE_EXEC: begin
        // A stalled EXEC freezes everything, including any jump request.
        if (!exec_stall_i) begin
          if (instr0_q[31:24] == OP_END) begin
            state_d = STATE_HALT;
          end else begin
            if (jump_req_i) pc_d = jump_target_i;
`ifdef STEP_MODE_EN
            state_d = STATE_PAUSE;
`else
            state_d = STATE_FETCH0;
`endif
          end
        end
      end
`ifdef STEP_MODE_EN
      STATE_PAUSE: begin
        if (step_i) state_d = STATE_FETCH0;
      end
`endif
      default: begin
        state_d = STATE_HALT;
      end
    endcase
  end

  // State and datapath registers; reset overrides every other input.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= STATE_HALT;
      pc_q     <= '0;
      instr0_q <= '0;
      instr1_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr0_q <= instr0_d;
      instr1_q <= instr1_d;
    end
  end

  assign mem_bus.mem_re   = rd_en;
  assign mem_bus.mem_addr = rd_addr;
  assign current_state_o  = state_q;
  assign instr0_o         = instr0_q;
  assign instr1_o         = instr1_q;
  assign pc_o             = pc_q;
  assign halted_o         = (state_q == STATE_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - randomized self-checking bench for fetch_ctrl against an instruction-level model
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        exec_stall = 1'b0;
  logic        jump_req = 1'b0;
  logic [15:0] jump_target = '0;
  logic        step = 1'b0;
  logic [3:0]  cur_state;
  logic [31:0] instr0, instr1;
  logic [15:0] pc;
  logic        halted;

  fetch_ctrl_if mem_if();

  fetch_ctrl dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .start_i         (start),
    .exec_stall_i    (exec_stall),
    .jump_req_i      (jump_req),
    .jump_target_i   (jump_target),
    .step_i          (step),
    .mem_bus         (mem_if),
    .current_state_o (cur_state),
    .instr0_o        (instr0),
    .instr1_o        (instr1),
    .pc_o            (pc),
    .halted_o        (halted)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];

  // Registered memory: data valid the cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (mem_if.mem_re) mem_if.mem_rdata <= mem[mem_if.mem_addr];
    else               mem_if.mem_rdata <= $urandom;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] m_pc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_two_word(input logic [7:0] op);
    return (op == OP_LIMM32) || (op == OP_LBSET);
  endfunction

  function automatic logic [31:0] rand_word();
    int r;
    logic [7:0] op;
    r = $urandom_range(0, 99);
    if (r < 25)      op = OP_LIMM32;
    else if (r < 35) op = OP_LBSET;
    else if (r < 39) op = OP_END;
    else if (r < 60) op = OP_LIMM16;
    else             op = 8'($urandom);
    return {op, 24'($urandom)};
  endfunction

  task automatic check_halt_state(input string tag);
    check({tag, "_state"}, 32'(cur_state), 32'(STATE_HALT));
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_re"}, 32'(mem_if.mem_re), 32'd0);
    check({tag, "_addr"}, 32'(mem_if.mem_addr), 32'd0);
  endtask

  // Called at a negedge while halted; leaves the bench at the FETCH0 negedge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one whole instruction from FETCH0 to the next FETCH0 or HALT.
  task automatic run_instr(input int stalls, input bit jmp, input logic [15:0] tgt,
                           output bit ended);
    logic [31:0] w0, w1;
    bit two;
    ended = 1'b0;
    check("f0_state", 32'(cur_state), 32'(STATE_FETCH0));
    check("f0_re", 32'(mem_if.mem_re), 32'd1);
    check("f0_addr", 32'(mem_if.mem_addr), 32'(m_pc));
    check("f0_halted", 32'(halted), 32'd0);
    w0 = mem[m_pc];
    two = model_two_word(w0[31:24]);
    m_pc = m_pc + 16'd1;
    start = 1'($urandom);
    @(negedge clk);
    check("l0_state", 32'(cur_state), 32'(STATE_LATCH0));
    check("l0_re", 32'(mem_if.mem_re), 32'd0);
    w1 = '0;
    if (two) begin
      w1 = mem[m_pc];
      @(negedge clk);
      check("f1_state", 32'(cur_state), 32'(STATE_FETCH1));
      check("f1_re", 32'(mem_if.mem_re), 32'd1);
      check("f1_addr", 32'(mem_if.mem_addr), 32'(m_pc));
      m_pc = m_pc + 16'd1;
      @(negedge clk);
      check("l1_state", 32'(cur_state), 32'(STATE_LATCH1));
    end
    start = 1'b0;
    @(negedge clk);
    check("ex_state", 32'(cur_state), 32'(STATE_EXEC));
    check("ex_instr0", instr0, w0);
    check("ex_instr1", instr1, w1);
    check("ex_pc", 32'(pc), 32'(m_pc));
    check("ex_re", 32'(mem_if.mem_re), 32'd0);
    for (int s = 0; s < stalls; s++) begin
      exec_stall  = 1'b1;
      jump_req    = 1'($urandom);
      jump_target = 16'($urandom);
      start       = 1'($urandom);
      step        = 1'($urandom);
      @(negedge clk);
      check("stall_state", 32'(cur_state), 32'(STATE_EXEC));
      check("stall_instr0", instr0, w0);
      check("stall_instr1", instr1, w1);
      check("stall_pc", 32'(pc), 32'(m_pc));
    end
    exec_stall  = 1'b0;
    start       = 1'b0;
    step        = 1'b0;
    jump_req    = jmp;
    jump_target = tgt;
    @(negedge clk);
    jump_req = 1'b0;
    if (w0[31:24] == OP_END) begin
      ended = 1'b1;
      check_halt_state("end");
      check("end_pc", 32'(pc), 32'(m_pc));
    end else begin
      if (jmp) m_pc = tgt;
      check("exit_pc", 32'(pc), 32'(m_pc));
`ifdef STEP_MODE_EN
      for (int h = 0; h < 2; h++) begin
        check("pause_state", 32'(cur_state), 32'(STATE_PAUSE));
        check("pause_re", 32'(mem_if.mem_re), 32'd0);
        start = 1'($urandom);
        @(negedge clk);
      end
      check("pause_hold", 32'(cur_state), 32'(STATE_PAUSE));
      start = 1'b0;
      step  = 1'b1;
      @(negedge clk);
      step  = 1'b0;
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bit ended;
    for (int a = 0; a < 65536; a++) mem[a] = rand_word();
    mem[16'h0000] = {OP_LIMM16, 24'h123456};
    mem[16'h0001] = {OP_LIMM32, 24'h000001};
    mem[16'h0002] = 32'hDEADBEEF;
    mem[16'h0003] = {OP_LIMM16, 24'h000003};
    mem[16'h0040] = {OP_LBSET,  24'h000040};
    mem[16'h0041] = 32'h0BADF00D;
    mem[16'hFFFF] = {OP_END,    24'h00FFFF};
    mem[16'h0100] = {OP_LIMM32, 24'h000100};
    mem[16'h0101] = 32'hCAFEF00D;

    repeat (3) @(negedge clk);
    check_halt_state("rst");
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr0", instr0, 32'd0);
    check("rst_instr1", instr1, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_halt_state("idle");
    do_start();

    run_instr(0, 1'b0, 16'h0000, ended);
    run_instr(0, 1'b0, 16'h0000, ended);
    run_instr(3, 1'b1, 16'h0040, ended);
    run_instr(1, 1'b1, 16'hFFFF, ended);
    run_instr(0, 1'b0, 16'h0000, ended);
    check("wrap_ended", 32'(ended), 32'd1);
    check("wrap_pc", 32'(pc), 32'd0);
    @(negedge clk);
    check_halt_state("hold");
    do_start();
    run_instr(0, 1'b1, 16'h0100, ended);

    // Interrupt the two-word fetch at 0x0100 with reset during LATCH1.
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_state", 32'(cur_state), 32'(STATE_LATCH1));
    reset = 1'b1;
    start = 1'b1;
    jump_req = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    jump_req = 1'b0;
    check_halt_state("mid_rst");
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_instr0", instr0, 32'd0);
    check("mid_rst_instr1", instr1, 32'd0);
    m_pc = '0;
    do_start();

    for (int n = 0; n < 250; n++) begin
      run_instr($urandom_range(0, 3), ($urandom_range(0, 3) == 0), 16'($urandom), ended);
      if (ended) do_start();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL: start  input  1  one-cycle pulse; leaves HALT and begins fetching at pc.
REQ-004 SHALL: mem_re  output  1  instruction-memory read enable.
REQ-005 SHALL: mem_addr  output  16  instruction word address (equals pc while mem_re=1, else 0).
REQ-006 SHALL: mem_rdata  input  32  read data, valid exactly one cycle after mem_re.
REQ-007 SHALL: exec_stall  input  1  datapath requests that EXEC be held one more cycle.
REQ-008 SHALL: jump_req  input  1  taken branch, sampled on the EXEC exit cycle.
REQ-009 SHALL: jump_target  input  16  next pc when jump_req is sampled high.
REQ-010 SHALL: step  input  1  single-step pulse (used only when STEP_MODE_EN is defined).
REQ-011 SHALL: current_state  output  4  registered state code, drives the datapath.
REQ-012 SHALL: instr0 / instr1  output  32 each  registered first/second instruction words.
REQ-013 SHALL: pc  output  16  address of the next word to fetch.
REQ-014 SHALL: halted  output  1  high iff current_state == STATE_HALT.

Function
REQ-015 SHALL: states are HALT, FETCH0, LATCH0, FETCH1, LATCH1, EXEC and PAUSE, with state codes defined in def.v.
REQ-016 SHALL: HALT transitions to FETCH0 on start and otherwise holds; start is ignored in every other state.
REQ-017 SHALL: FETCH0 assert mem_re with mem_addr=pc, then go to LATCH0.
REQ-018 SHALL: LATCH0 set instr0<=mem_rdata and pc<=pc+1, then go to FETCH1 if mem_rdata[31:24] is OP_LIMM32 or OP_LBSET, else go to EXEC.
REQ-019 SHALL: for a one-word instruction, LATCH0 also set instr1<=0.
REQ-020 SHALL: FETCH1 assert mem_re with mem_addr=pc, then go to LATCH1.
REQ-021 SHALL: LATCH1 set instr1<=mem_rdata and pc<=pc+1, then go to EXEC.
REQ-022 SHALL: EXEC hold while exec_stall=1, with instr0, instr1 and pc stable; jump_req is ignored while stalled.
REQ-023 SHALL: EXEC exit, when instr0[31:24]==OP_END, go to HALT with pc unchanged.
REQ-024 SHALL: EXEC exit otherwise go to FETCH0, or to PAUSE under STEP_MODE_EN, loading pc<=jump_target if jump_req=1.
REQ-025 SHALL: latency from FETCH0 entry to EXEC entry is 2 cycles for one-word and 4 cycles for two-word instructions; an unstalled EXEC lasts 1 cycle.
REQ-026 SHALL: pc arithmetic is modulo 2^16 (16'hFFFF+1 = 16'h0000).
REQ-027 SHALL: mem_re is 0 in every state except FETCH0 and FETCH1.
REQ-028 SHALL: states PAUSE and unused codes go to HALT when STEP_MODE_EN is undefined.

Reset
REQ-029 SHALL: reset, at any state including mid-fetch or mid-EXEC, force state=HALT, pc=0, instr0=0, instr1=0, mem_re=0, mem_addr=0 and halted=1 on the next edge.
REQ-030 SHALL: reset take priority over start, step, exec_stall and jump_req.

Configuration
REQ-031 SHALL: with STEP_MODE_EN defined, EXEC exit go to PAUSE and PAUSE go to FETCH0 on step=1, otherwise hold; a jump is applied to pc at EXEC exit.
REQ-032 SHALL: with STEP_MODE_EN undefined, the step port remain present but be ignored, and PAUSE be unreachable.

Structure
REQ-033 SHALL: STATE_* codes (4-bit), OP_END, OP_LIMM32 and OP_LBSET live in shared def.v; the module contains no literal state or opcode values.
REQ-034 SHALL: the two-word detection be one combinational sub-module, instr_len (input 8-bit opcode, output is_two_word).

Verification
REQ-035 SHALL: OP_LIMM16 at addr 0 -> after start: FETCH0, LATCH0, EXEC in 3 cycles, instr0 = word0, instr1 = 0, pc = 1.
REQ-036 SHALL: OP_LIMM32 at 0 with imm 32'hDEADBEEF at 1 -> EXEC entered 4 cycles after FETCH0 with instr1 = 32'hDEADBEEF, pc = 2.
REQ-037 SHALL: EXEC with exec_stall high 3 cycles and jump_req=1, jump_target=16'h0040 on the 4th cycle -> 4 EXEC cycles, then FETCH0 with mem_addr = 16'h0040.
REQ-038 SHALL: OP_END at 16'hFFFF with pc pre-wrapped -> pc = 0 after LATCH0, then HALT with halted=1, and a later start fetches addr 0.
REQ-039 SHALL: reset asserted in LATCH1 -> next cycle state HALT, pc = 0, instr0 = instr1 = 0, mem_re = 0.
REQ-040 SHALL: with STEP_MODE_EN defined, two instructions -> PAUSE after each EXEC, and no FETCH0 until a step pulse.
